// File: rtl/param_counter.sv
// Parameterised up/down modulo counter with wrap or saturate boundary mode,
// one-cycle terminal-count pulse and a sticky boundary-event flag.
module param_counter #(
    parameter int unsigned      WIDTH = 4,
    parameter longint unsigned  MOD   = 16,
    parameter int unsigned      SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    // The modulus can reach 2**WIDTH, so the top count is formed from a 64-bit parameter.
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;

    logic             w_boundary;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_load;

    always_comb begin
        w_boundary = up ? (r_cnt == MAXV) : (r_cnt == '0);
        w_step     = up ? (r_cnt + ONE) : (r_cnt - ONE);
        w_wrap     = up ? '0 : MAXV;
        w_load     = (load_val > MAXV) ? MAXV : load_val;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_cnt <= w_load;
            r_tc  <= 1'b0;
        end else if (en) begin
            if (w_boundary) begin
                // Saturating mode simply leaves the count at its limit.
                if (SAT == 0) begin
                    r_cnt <= w_wrap;
                end
                r_tc  <= 1'b1;
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= w_step;
                r_tc  <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign cnt = r_cnt;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning counter width in bits (legal 1..32).
REQ-002 The block SHALL have parameter MOD, default 16, meaning count modulus (legal 2..2**WIDTH); the count range is 0..MOD-1.
REQ-003 The block SHALL have parameter SAT, default 0, meaning boundary mode: 0 = wrap-around, 1 = saturate.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clr  input  1  synchronous clear of count and sticky flag.
REQ-007 load  input  1  synchronous parallel load request.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 en  input  1  count enable; one step per enabled cycle.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 cnt  output  WIDTH  registered count value.
REQ-012 tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 ovf  output  1  registered sticky boundary-event flag.

Function
REQ-014 Per-edge priority SHALL be rst > clr > load > en; lower-priority requests in the same cycle SHALL be ignored.
REQ-015 clr SHALL set cnt=0, tc=0, ovf=0.
REQ-016 load SHALL set cnt=load_val when load_val<=MOD-1, else cnt=MOD-1; tc=0; ovf unchanged.
REQ-017 en=0 with no rst/clr/load SHALL hold cnt, drive tc=0, and hold ovf.
REQ-018 en=1, up=1, cnt<MOD-1 SHALL set cnt=cnt+1, tc=0.
REQ-019 en=1, up=0, cnt>0 SHALL set cnt=cnt-1, tc=0.
REQ-020 Boundary event: en=1 with (up=1, cnt=MOD-1) or (up=0, cnt=0).
REQ-021 On a boundary event with SAT=0, cnt SHALL become 0 (up) or MOD-1 (down).
REQ-022 On a boundary event with SAT=1, cnt SHALL hold its value.
REQ-023 On every boundary event, tc SHALL be 1 for exactly the following cycle, and ovf SHALL be set to 1.
REQ-024 Consecutive boundary events (SAT=1 held at a limit, or MOD=2 in wrap mode) SHALL keep tc=1 on every such cycle.
REQ-025 Arithmetic SHALL be modulo-MOD with no intermediate overflow; when MOD=2**WIDTH, wrap SHALL equal natural WIDTH-bit rollover.
REQ-026 Direction changes SHALL take effect on the same edge with no dead cycle.
REQ-027 cnt SHALL never present a value >= MOD.

Reset
REQ-028 rst=1 at a rising edge SHALL set cnt=0, tc=0, ovf=0, regardless of all other inputs.
REQ-029 rst asserted during counting SHALL take effect on that edge; counting SHALL resume from 0 on the first edge with rst=0 and en=1.
REQ-030 Output values before the first reset edge are undefined; the bench SHALL apply reset first.

Verification
REQ-031 Defaults, rst 1 cycle, then en=1, up=1 for 17 cycles -> cnt runs 0,1..15,0,1; tc=1 only in the cycle after cnt 15->0; ovf=1 from then on.
REQ-032 MOD=10, SAT=0, load load_val=3, then en=1, up=0 for 5 cycles -> cnt 3,2,1,0,9,8; tc=1 in the cycle cnt shows 9; load_val=12 -> cnt=9.
REQ-033 MOD=10, SAT=1, up=1 from cnt=7 for 5 cycles -> cnt 8,9,9,9,9; tc=1 on each of the 3 held cycles; ovf=1.
REQ-034 Same edge rst=1, clr=1, load=1 (load_val=5), en=1 -> cnt=0, ovf=0; next edge clr=0, load=1, en=1 -> cnt=5 (load beats en).
REQ-035 After ovf=1, en toggled with clr=0 -> ovf stays 1; single clr pulse -> cnt=0, ovf=0, tc=0 on the next cycle.
REQ-036 WIDTH=8, MOD=256, cnt=255, up=1, en=1 -> cnt=0, tc=1; rst asserted mid-count at cnt=0x40 -> cnt=0 on that edge.
